// File: rtl/retire_stage.sv
// retire_stage: writeback/completion stage of the Qu out-of-order core.
// Collects results from the ALU/branch port and the load/store port,
// drives data memory, queues completions in a small FIFO, writes the
// physical register file / busy table and reports completion to the ROB.

package retire_pkg;
  // Field widths of the reservation-station cell shared with the issue logic.
  localparam int CELL_PHY_W = 6;
  localparam int CELL_ROB_W = 4;

  localparam logic [2:0] OP_NONE   = 3'b000;
  localparam logic [2:0] OP_LOAD   = 3'b001;
  localparam logic [2:0] OP_STORE  = 3'b010;
  localparam logic [2:0] OP_ALU    = 3'b011;
  localparam logic [2:0] OP_BRANCH = 3'b100;
  localparam logic [2:0] OP_JUMP   = 3'b101;

  typedef struct packed {
    logic                  busy;
    logic [2:0]            op;
    logic [CELL_PHY_W-1:0] qj;
    logic [CELL_PHY_W-1:0] qk;
    logic [31:0]           vj;
    logic [31:0]           vk;
    logic [31:0]           a;
    logic [CELL_PHY_W-1:0] dest;
    logic [CELL_ROB_W-1:0] rob_addr;
  } res_st_cell_t;
endpackage

module retire_stage
  import retire_pkg::*;
#(
  parameter int PHY_RF_ADDR_WIDTH = CELL_PHY_W,
  parameter int DATA_WIDTH        = 32,
  parameter int ROB_ADDR_WIDTH    = CELL_ROB_W,
  parameter int MEM_DEPTH         = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATA_WIDTH-1:0]        value1_in,
  input  logic [DATA_WIDTH-1:0]        value2_in,
  input  logic                         comp_result_in,
  input  res_st_cell_t                 op1_in,
  input  res_st_cell_t                 op2_in,
  output logic                         phy_rf_wr_en,
  output logic [PHY_RF_ADDR_WIDTH-1:0] phy_rf_wr_addr,
  output logic [DATA_WIDTH-1:0]        phy_rf_wr_data,
  output logic [PHY_RF_ADDR_WIDTH-1:0] phyreg_renamed_free_reg_addr,
  output logic                         busy_table_wr_en,
  output logic [PHY_RF_ADDR_WIDTH-1:0] busy_table_wr_addr,
  output logic                         busy_table_wr_data,
  output logic [ROB_ADDR_WIDTH-1:0]    rob_tail_ptr,
  input  logic                         rob_incr_tail_ptr,
  output logic                         rob_full,
  output logic                         retire_en,
  output logic [ROB_ADDR_WIDTH-1:0]    retire_rob_addr,
  output logic [DATA_WIDTH-1:0]        retire_value,
  output logic                         mispredicted_branch,
  output logic [DATA_WIDTH-1:0]        pc_to_jump,
  output logic [3:0]                   dmem_wr_en_out,
  output logic                         dmem_rd_en_out,
  output logic [DATA_WIDTH-1:0]        dmem_addr_out,
  output logic [DATA_WIDTH-1:0]        dmem_data_out,
  input  logic                         dmem_valid_in,
  input  logic [$clog2(MEM_DEPTH)-1:0] dmem_valid_addr_in,
  input  logic [DATA_WIDTH-1:0]        dmem_data_in
);

  localparam int MEM_AW    = $clog2(MEM_DEPTH);
  localparam int QDEPTH    = 4;
  localparam int NPUSH     = 3;
  localparam int ROB_DEPTH = 1 << ROB_ADDR_WIDTH;
  localparam int OCC_W     = ROB_ADDR_WIDTH + 1;

  typedef struct packed {
    logic                         wb;
    logic [PHY_RF_ADDR_WIDTH-1:0] dest;
    logic [ROB_ADDR_WIDTH-1:0]    rob;
    logic [DATA_WIDTH-1:0]        value;
  } wb_entry_t;

  // Operand/tag fields this stage never looks at.
  logic unused_fields;
  assign unused_fields = ^{op1_in.qj, op1_in.qk, op1_in.vj, op1_in.vk,
                           op2_in.qj, op2_in.qk, op2_in.vj, op2_in.a};

  // Port decode: each port only honours its own class of micro-ops.
  logic p1_alu, p1_br, p1_jmp, p2_ld, p2_st;
  assign p1_alu = op1_in.busy && (op1_in.op == OP_ALU);
  assign p1_br  = op1_in.busy && (op1_in.op == OP_BRANCH);
  assign p1_jmp = op1_in.busy && (op1_in.op == OP_JUMP);
  assign p2_ld  = op2_in.busy && (op2_in.op == OP_LOAD);
  assign p2_st  = op2_in.busy && (op2_in.op == OP_STORE);

  // Pending-load register
  logic                         pend_valid_q, pend_valid_d;
  logic [PHY_RF_ADDR_WIDTH-1:0] pend_dest_q, pend_dest_d;
  logic [ROB_ADDR_WIDTH-1:0]    pend_rob_q, pend_rob_d;
  logic [MEM_AW-1:0]            pend_waddr_q, pend_waddr_d;

  logic load_accept, load_hit;
  assign load_accept = p2_ld && !pend_valid_q;
  assign load_hit    = pend_valid_q && dmem_valid_in && (dmem_valid_addr_in == pend_waddr_q);

  // Writeback FIFO state
  logic [1:0] head_q, head_d;
  logic [2:0] count_q, count_d;
  wb_entry_t  mem_rd [QDEPTH];

  // Push candidates in priority order: port 1, store, load return.
  logic [NPUSH-1:0] push_v;
  logic [NPUSH-1:0] push_acc;
  wb_entry_t        push_e    [NPUSH];
  logic [1:0]       push_slot [NPUSH];
  logic [2:0]       fill;
  logic [2:0]       total;
  logic             pop;
  wb_entry_t        bypass_e, head_e;

  // Build the three possible queue entries for this cycle
  always_comb begin
    push_v[0]       = p1_alu || p1_br || p1_jmp;
    push_e[0].wb    = !p1_br;
    push_e[0].dest  = p1_br ? '0 : op1_in.dest;
    push_e[0].rob   = op1_in.rob_addr;
    push_e[0].value = p1_br ? '0 : value1_in;
    push_v[1]       = p2_st;
    push_e[1].wb    = 1'b0;
    push_e[1].dest  = '0;
    push_e[1].rob   = op2_in.rob_addr;
    push_e[1].value = '0;
    push_v[2]       = load_hit;
    push_e[2].wb    = 1'b1;
    push_e[2].dest  = pend_dest_q;
    push_e[2].rob   = pend_rob_q;
    push_e[2].value = dmem_data_in;
  end

  // Accept pushes in order; the slot being popped this cycle counts as free,
  // so up to five entries (four stored plus the one leaving) may coexist.
  always_comb begin
    fill = count_q;
    for (int i = 0; i < NPUSH; i++) begin
      push_acc[i]  = push_v[i] && (fill < 3'd5);
      push_slot[i] = head_q + fill[1:0];
      fill         = fill + {2'b00, push_acc[i]};
    end
    total = fill;
    pop   = (total != 3'd0);
  end

  // Pick the entry leaving this cycle: stored head, else first accepted push
  always_comb begin
    bypass_e = '0;
    for (int i = NPUSH - 1; i >= 0; i--) begin
      if (push_acc[i]) bypass_e = push_e[i];
    end
    head_e = (count_q != 3'd0) ? mem_rd[head_q] : bypass_e;
  end

  // FIFO storage, one register per slot
  genvar gi;
  generate
    for (gi = 0; gi < QDEPTH; gi++) begin : g_slot
      wb_entry_t slot_q, slot_d;
      // Capture whichever accepted push targets this slot
      always_comb begin
        slot_d = slot_q;
        for (int i = 0; i < NPUSH; i++) begin
          if (push_acc[i] && (push_slot[i] == 2'(gi))) slot_d = push_e[i];
        end
      end
      // Slot contents need no reset; the occupancy count qualifies them
      always_ff @(posedge clk) begin
        slot_q <= slot_d;
      end
      assign mem_rd[gi] = slot_q;
    end
  endgenerate

  // Registered outputs and ROB tracking
  logic                         retire_en_q, retire_en_d;
  logic [ROB_ADDR_WIDTH-1:0]    retire_rob_q, retire_rob_d;
  logic [DATA_WIDTH-1:0]        retire_value_q, retire_value_d;
  logic                         rf_wr_en_q, rf_wr_en_d;
  logic [PHY_RF_ADDR_WIDTH-1:0] rf_addr_q, rf_addr_d;
  logic [DATA_WIDTH-1:0]        rf_data_q, rf_data_d;
  logic                         mispred_q, mispred_d;
  logic [DATA_WIDTH-1:0]        pc_q, pc_d;
  logic [3:0]                   dmem_wr_q, dmem_wr_d;
  logic                         dmem_rd_q, dmem_rd_d;
  logic [DATA_WIDTH-1:0]        dmem_addr_q, dmem_addr_d;
  logic [DATA_WIDTH-1:0]        dmem_data_q, dmem_data_d;
  logic [ROB_ADDR_WIDTH-1:0]    tail_q, tail_d;
  logic [OCC_W-1:0]             occ_q, occ_d;
  logic                         rob_full_q, rob_full_d;
  logic                         alloc, rf_write;

  // Next-state logic for everything outside the FIFO slots
  always_comb begin
    // completion / writeback
    rf_write       = pop && head_e.wb && (head_e.dest != '0);
    retire_en_d    = pop;
    retire_rob_d   = pop ? head_e.rob : '0;
    retire_value_d = pop ? head_e.value : '0;
    rf_wr_en_d     = rf_write;
    rf_addr_d      = rf_write ? head_e.dest : '0;
    rf_data_d      = rf_write ? head_e.value : '0;
    head_d         = head_q + {1'b0, pop};
    count_d        = pop ? (total - 3'd1) : 3'd0;

    // redirect: static not-taken, so only taken branches and jumps redirect
    mispred_d = p1_jmp || (p1_br && comp_result_in);
    pc_d      = mispred_d ? op1_in.a : '0;

    // data memory request
    dmem_wr_d   = p2_st ? 4'b1111 : 4'b0000;
    dmem_rd_d   = load_accept;
    dmem_addr_d = (p2_st || load_accept) ? value2_in : '0;
    dmem_data_d = p2_st ? op2_in.vk : '0;

    // pending load: a match clears it, a new load only lands when it is empty
    pend_valid_d = pend_valid_q;
    pend_dest_d  = pend_dest_q;
    pend_rob_d   = pend_rob_q;
    pend_waddr_d = pend_waddr_q;
    if (load_hit) begin
      pend_valid_d = 1'b0;
    end else if (load_accept) begin
      pend_valid_d = 1'b1;
      pend_dest_d  = op2_in.dest;
      pend_rob_d   = op2_in.rob_addr;
      pend_waddr_d = value2_in[2 +: MEM_AW];
    end

    // ROB allocation; a retire with nothing outstanding cannot underflow
    alloc  = rob_incr_tail_ptr && !rob_full_q;
    tail_d = tail_q + ROB_ADDR_WIDTH'(alloc);
    occ_d  = occ_q + OCC_W'(alloc);
    if (retire_en_q && (occ_d != '0)) occ_d = occ_d - OCC_W'(1);
    rob_full_d = (occ_d == OCC_W'(ROB_DEPTH));
  end

  // State update with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      head_q         <= '0;
      count_q        <= '0;
      pend_valid_q   <= 1'b0;
      pend_dest_q    <= '0;
      pend_rob_q     <= '0;
      pend_waddr_q   <= '0;
      retire_en_q    <= 1'b0;
      retire_rob_q   <= '0;
      retire_value_q <= '0;
      rf_wr_en_q     <= 1'b0;
      rf_addr_q      <= '0;
      rf_data_q      <= '0;
      mispred_q      <= 1'b0;
      pc_q           <= '0;
      dmem_wr_q      <= '0;
      dmem_rd_q      <= 1'b0;
      dmem_addr_q    <= '0;
      dmem_data_q    <= '0;
      tail_q         <= '0;
      occ_q          <= '0;
      rob_full_q     <= 1'b0;
    end else begin
      head_q         <= head_d;
      count_q        <= count_d;
      pend_valid_q   <= pend_valid_d;
      pend_dest_q    <= pend_dest_d;
      pend_rob_q     <= pend_rob_d;
      pend_waddr_q   <= pend_waddr_d;
      retire_en_q    <= retire_en_d;
      retire_rob_q   <= retire_rob_d;
      retire_value_q <= retire_value_d;
      rf_wr_en_q     <= rf_wr_en_d;
      rf_addr_q      <= rf_addr_d;
      rf_data_q      <= rf_data_d;
      mispred_q      <= mispred_d;
      pc_q           <= pc_d;
      dmem_wr_q      <= dmem_wr_d;
      dmem_rd_q      <= dmem_rd_d;
      dmem_addr_q    <= dmem_addr_d;
      dmem_data_q    <= dmem_data_d;
      tail_q         <= tail_d;
      occ_q          <= occ_d;
      rob_full_q     <= rob_full_d;
    end
  end

  assign retire_en                    = retire_en_q;
  assign retire_rob_addr              = retire_rob_q;
  assign retire_value                 = retire_value_q;
  assign phy_rf_wr_en                 = rf_wr_en_q;
  assign phy_rf_wr_addr               = rf_addr_q;
  assign phy_rf_wr_data               = rf_data_q;
  assign phyreg_renamed_free_reg_addr = rf_addr_q;
  assign busy_table_wr_en             = rf_wr_en_q;
  assign busy_table_wr_addr           = rf_addr_q;
  assign busy_table_wr_data           = 1'b0;
  assign mispredicted_branch          = mispred_q;
  assign pc_to_jump                   = pc_q;
  assign dmem_wr_en_out               = dmem_wr_q;
  assign dmem_rd_en_out               = dmem_rd_q;
  assign dmem_addr_out                = dmem_addr_q;
  assign dmem_data_out                = dmem_data_q;
  assign rob_tail_ptr                 = tail_q;
  assign rob_full                     = rob_full_q;

endmodule

// File: tb/tb_retire_stage.sv
// Bench for retire_stage: directed vectors, a queue-based reference model
// checked every cycle, and literal expectations at key points.
module tb_retire_stage;
  import retire_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic [31:0] value1_in, value2_in;
  logic comp_result_in;
  res_st_cell_t op1_in, op2_in;
  logic phy_rf_wr_en;
  logic [5:0] phy_rf_wr_addr;
  logic [31:0] phy_rf_wr_data;
  logic [5:0] phyreg_renamed_free_reg_addr;
  logic busy_table_wr_en;
  logic [5:0] busy_table_wr_addr;
  logic busy_table_wr_data;
  logic [3:0] rob_tail_ptr;
  logic rob_incr_tail_ptr;
  logic rob_full;
  logic retire_en;
  logic [3:0] retire_rob_addr;
  logic [31:0] retire_value;
  logic mispredicted_branch;
  logic [31:0] pc_to_jump;
  logic [3:0] dmem_wr_en_out;
  logic dmem_rd_en_out;
  logic [31:0] dmem_addr_out, dmem_data_out;
  logic dmem_valid_in;
  logic [9:0] dmem_valid_addr_in;
  logic [31:0] dmem_data_in;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  retire_stage dut (
    .clk(clk), .rst(rst),
    .value1_in(value1_in), .value2_in(value2_in), .comp_result_in(comp_result_in),
    .op1_in(op1_in), .op2_in(op2_in),
    .phy_rf_wr_en(phy_rf_wr_en), .phy_rf_wr_addr(phy_rf_wr_addr), .phy_rf_wr_data(phy_rf_wr_data),
    .phyreg_renamed_free_reg_addr(phyreg_renamed_free_reg_addr),
    .busy_table_wr_en(busy_table_wr_en), .busy_table_wr_addr(busy_table_wr_addr),
    .busy_table_wr_data(busy_table_wr_data),
    .rob_tail_ptr(rob_tail_ptr), .rob_incr_tail_ptr(rob_incr_tail_ptr), .rob_full(rob_full),
    .retire_en(retire_en), .retire_rob_addr(retire_rob_addr), .retire_value(retire_value),
    .mispredicted_branch(mispredicted_branch), .pc_to_jump(pc_to_jump),
    .dmem_wr_en_out(dmem_wr_en_out), .dmem_rd_en_out(dmem_rd_en_out),
    .dmem_addr_out(dmem_addr_out), .dmem_data_out(dmem_data_out),
    .dmem_valid_in(dmem_valid_in), .dmem_valid_addr_in(dmem_valid_addr_in),
    .dmem_data_in(dmem_data_in)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic        wb;
    logic [5:0]  dest;
    logic [3:0]  rob;
    logic [31:0] val;
  } ent_t;

  ent_t q[$];
  ent_t pq[$];
  ent_t e, outq;
  bit   have, old_pv;
  bit   m_ok = 0;
  bit   pend_v;
  logic [5:0] pend_dest;
  logic [3:0] pend_rob;
  logic [9:0] pend_w;
  int   occ, tail;
  logic [2:0] p1op, p2op;
  logic m_ret_en, m_rf_en, m_full, m_mis, m_rd;
  logic [3:0] m_ret_rob, m_wr;
  logic [31:0] m_ret_val, m_rf_data, m_pc, m_daddr, m_ddata;
  logic [5:0] m_rf_addr;

  always @(posedge clk) begin
    if (!rst) begin
      q.delete();
      pend_v = 0; occ = 0; tail = 0;
      m_ret_en = 0; m_ret_rob = 0; m_ret_val = 0; m_rf_en = 0; m_rf_addr = 0; m_rf_data = 0;
      m_full = 0; m_mis = 0; m_pc = 0; m_wr = 0; m_rd = 0; m_daddr = 0; m_ddata = 0;
    end else begin
      // ROB occupancy: allocations when not full, minus the retire shown this cycle
      if (rob_incr_tail_ptr && !m_full) begin
        occ = occ + 1;
        tail = (tail + 1) % 16;
      end
      if (m_ret_en && occ > 0) occ = occ - 1;
      m_full = (occ == 16);

      p1op = op1_in.busy ? op1_in.op : 3'd0;
      p2op = op2_in.busy ? op2_in.op : 3'd0;
      pq.delete();
      m_mis = 0; m_pc = 0; m_wr = 0; m_rd = 0; m_daddr = 0; m_ddata = 0;

      if (p1op == 3'd3 || p1op == 3'd5) begin
        e.wb = 1; e.dest = op1_in.dest; e.rob = op1_in.rob_addr; e.val = value1_in;
        pq.push_back(e);
      end else if (p1op == 3'd4) begin
        e.wb = 0; e.dest = 0; e.rob = op1_in.rob_addr; e.val = 0;
        pq.push_back(e);
      end
      if (p1op == 3'd5 || (p1op == 3'd4 && comp_result_in)) begin
        m_mis = 1; m_pc = op1_in.a;
      end
      if (p2op == 3'd2) begin
        e.wb = 0; e.dest = 0; e.rob = op2_in.rob_addr; e.val = 0;
        pq.push_back(e);
        m_wr = 4'hf; m_daddr = value2_in; m_ddata = op2_in.vk;
      end
      old_pv = pend_v;
      if (old_pv && dmem_valid_in && dmem_valid_addr_in == pend_w) begin
        e.wb = 1; e.dest = pend_dest; e.rob = pend_rob; e.val = dmem_data_in;
        pq.push_back(e);
        pend_v = 0;
      end
      if (p2op == 3'd1 && !old_pv) begin
        m_rd = 1; m_daddr = value2_in;
        pend_v = 1; pend_dest = op2_in.dest; pend_rob = op2_in.rob_addr; pend_w = value2_in[11:2];
      end

      // FIFO: take the oldest stored entry, add new ones while room, else bypass
      have = 0;
      if (q.size() > 0) begin outq = q.pop_front(); have = 1; end
      foreach (pq[i]) if (q.size() < 4) q.push_back(pq[i]);
      if (!have && q.size() > 0) begin outq = q.pop_front(); have = 1; end

      m_ret_en = have;
      m_ret_rob = have ? outq.rob : 4'd0;
      m_ret_val = have ? outq.val : 32'd0;
      m_rf_en = have && outq.wb && outq.dest != 0;
      m_rf_addr = m_rf_en ? outq.dest : 6'd0;
      m_rf_data = m_rf_en ? outq.val : 32'd0;
    end
    m_ok = 1;
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (m_ok) begin
      check("retire_en", 32'(retire_en), 32'(m_ret_en));
      check("retire_rob", 32'(retire_rob_addr), 32'(m_ret_rob));
      check("retire_val", retire_value, m_ret_val);
      check("rf_en", 32'(phy_rf_wr_en), 32'(m_rf_en));
      check("rf_addr", 32'(phy_rf_wr_addr), 32'(m_rf_addr));
      check("rf_data", phy_rf_wr_data, m_rf_data);
      check("free_addr", 32'(phyreg_renamed_free_reg_addr), 32'(m_rf_addr));
      check("bt_en", 32'(busy_table_wr_en), 32'(m_rf_en));
      check("bt_addr", 32'(busy_table_wr_addr), 32'(m_rf_addr));
      check("bt_data", 32'(busy_table_wr_data), 32'd0);
      check("tail", 32'(rob_tail_ptr), 32'(tail));
      check("full", 32'(rob_full), 32'(m_full));
      check("mispred", 32'(mispredicted_branch), 32'(m_mis));
      check("pc", pc_to_jump, m_pc);
      check("dmem_wr", 32'(dmem_wr_en_out), 32'(m_wr));
      check("dmem_rd", 32'(dmem_rd_en_out), 32'(m_rd));
      check("dmem_addr", dmem_addr_out, m_daddr);
      check("dmem_data", dmem_data_out, m_ddata);
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    op1_in = '0; op2_in = '0; value1_in = 0; value2_in = 0; comp_result_in = 0;
    dmem_valid_in = 0; dmem_valid_addr_in = 0; dmem_data_in = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic set_op1(input logic [2:0] op, input logic [5:0] dest, input logic [3:0] rob,
                         input logic [31:0] a, input logic [31:0] v1);
    op1_in = '0; op1_in.busy = 1; op1_in.op = op; op1_in.dest = dest;
    op1_in.rob_addr = rob; op1_in.a = a; value1_in = v1;
  endtask

  task automatic set_op2(input logic [2:0] op, input logic [5:0] dest, input logic [3:0] rob,
                         input logic [31:0] vk, input logic [31:0] v2);
    op2_in = '0; op2_in.busy = 1; op2_in.op = op; op2_in.dest = dest;
    op2_in.rob_addr = rob; op2_in.vk = vk; value2_in = v2;
  endtask

  initial begin
    rst = 0; rob_incr_tail_ptr = 0; idle();
    repeat (4) cyc();
    check("rst_retire_en", 32'(retire_en), 32'd0);
    check("rst_tail", 32'(rob_tail_ptr), 32'd0);
    check("rst_full", 32'(rob_full), 32'd0);
    check("rst_rf_en", 32'(phy_rf_wr_en), 32'd0);
    check("rst_dmem_wr", 32'(dmem_wr_en_out), 32'd0);
    rst = 1;

    // allocate every cycle until the ROB fills
    rob_incr_tail_ptr = 1;
    for (int k = 1; k <= 16; k++) begin
      cyc();
      check("alloc_tail", 32'(rob_tail_ptr), 32'(k % 16));
      check("alloc_full", 32'(rob_full), (k == 16) ? 32'd1 : 32'd0);
    end
    repeat (2) cyc();
    check("frozen_tail", 32'(rob_tail_ptr), 32'd0);
    check("frozen_full", 32'(rob_full), 32'd1);

    // ALU completion while full: one retire frees a slot
    set_op1(OP_ALU, 6'd3, 4'd1, 32'd0, 32'd15);
    cyc(); idle();
    check("alu_rf_en", 32'(phy_rf_wr_en), 32'd1);
    check("alu_rf_addr", 32'(phy_rf_wr_addr), 32'd3);
    check("alu_rf_data", phy_rf_wr_data, 32'd15);
    check("alu_bt_en", 32'(busy_table_wr_en), 32'd1);
    check("alu_bt_addr", 32'(busy_table_wr_addr), 32'd3);
    check("alu_ret_rob", 32'(retire_rob_addr), 32'd1);
    check("alu_ret_val", retire_value, 32'd15);
    cyc();
    check("unfull", 32'(rob_full), 32'd0);
    cyc();
    check("realloc_tail", 32'(rob_tail_ptr), 32'd1);
    check("refull", 32'(rob_full), 32'd1);
    rob_incr_tail_ptr = 0;

    // back-to-back ALU ops
    set_op1(OP_ALU, 6'd3, 4'd1, 32'd0, 32'h11);
    cyc();
    set_op1(OP_ALU, 6'd4, 4'd2, 32'd0, 32'h22);
    check("b2b0_addr", 32'(phy_rf_wr_addr), 32'd3);
    cyc(); idle();
    check("b2b1_addr", 32'(phy_rf_wr_addr), 32'd4);
    check("b2b1_data", phy_rf_wr_data, 32'h22);
    cyc();
    check("b2b_done", 32'(retire_en), 32'd0);

    // branches: taken redirects, not-taken does not
    set_op1(OP_BRANCH, 6'd0, 4'd5, 32'h100, 32'd0); comp_result_in = 1;
    cyc(); idle();
    check("br_mis", 32'(mispredicted_branch), 32'd1);
    check("br_pc", pc_to_jump, 32'h100);
    check("br_ret", 32'(retire_en), 32'd1);
    check("br_rf_en", 32'(phy_rf_wr_en), 32'd0);
    set_op1(OP_BRANCH, 6'd0, 4'd6, 32'h180, 32'd0); comp_result_in = 0;
    cyc(); idle();
    check("nt_mis", 32'(mispredicted_branch), 32'd0);
    check("nt_ret_rob", 32'(retire_rob_addr), 32'd6);

    // jump: link write plus redirect
    set_op1(OP_JUMP, 6'd7, 4'd7, 32'h200, 32'h44);
    cyc(); idle();
    check("jmp_pc", pc_to_jump, 32'h200);
    check("jmp_rf_data", phy_rf_wr_data, 32'h44);

    // wrong-port ops are ignored
    set_op1(OP_LOAD, 6'd2, 4'd3, 32'd0, 32'd0);
    set_op2(OP_ALU, 6'd2, 4'd3, 32'd0, 32'd4);
    cyc(); idle();
    check("wrongport_ret", 32'(retire_en), 32'd0);
    check("wrongport_rd", 32'(dmem_rd_en_out), 32'd0);

    // store
    set_op2(OP_STORE, 6'd0, 4'd8, 32'hAB, 32'd8);
    cyc(); idle();
    check("st_wr", 32'(dmem_wr_en_out), 32'hf);
    check("st_addr", dmem_addr_out, 32'd8);
    check("st_data", dmem_data_out, 32'hAB);
    check("st_rf_en", 32'(phy_rf_wr_en), 32'd0);

    // load, second load ignored while pending, wrong then right return
    set_op2(OP_LOAD, 6'd5, 4'd9, 32'd0, 32'd8);
    cyc();
    set_op2(OP_LOAD, 6'd9, 4'd10, 32'd0, 32'h40);
    check("ld_rd", 32'(dmem_rd_en_out), 32'd1);
    check("ld_addr", dmem_addr_out, 32'd8);
    cyc(); idle();
    check("ld2_ignored", 32'(dmem_rd_en_out), 32'd0);
    dmem_valid_in = 1; dmem_valid_addr_in = 10'h10; dmem_data_in = 32'h99;
    cyc(); idle();
    check("ld_wrong_ret", 32'(retire_en), 32'd0);
    dmem_valid_in = 1; dmem_valid_addr_in = 10'd2; dmem_data_in = 32'd4;
    cyc(); idle();
    check("ld_rf_addr", 32'(phy_rf_wr_addr), 32'd5);
    check("ld_rf_data", phy_rf_wr_data, 32'd4);

    // three pushes in one cycle: port 1, store, load return
    set_op2(OP_LOAD, 6'd6, 4'd11, 32'd0, 32'h20);
    cyc();
    set_op1(OP_ALU, 6'd10, 4'd12, 32'd0, 32'h55);
    set_op2(OP_STORE, 6'd0, 4'd13, 32'd1, 32'h30);
    dmem_valid_in = 1; dmem_valid_addr_in = 10'd8; dmem_data_in = 32'h77;
    cyc(); idle();
    check("mp0_rob", 32'(retire_rob_addr), 32'd12);
    cyc();
    check("mp1_rob", 32'(retire_rob_addr), 32'd13);
    cyc();
    check("mp2_rob", 32'(retire_rob_addr), 32'd11);
    check("mp2_data", phy_rf_wr_data, 32'h77);
    cyc();

    // overfill the queue so later pushes drop
    for (int i = 0; i < 6; i++) begin
      set_op1(OP_ALU, 6'(1 + i), 4'(i), 32'd0, 32'h100 + i);
      set_op2(OP_STORE, 6'd0, 4'(8 + i), 32'(i), 32'(4 * i));
      cyc();
    end
    idle();
    repeat (6) cyc();
    check("drain_done", 32'(retire_en), 32'd0);

    // write to register 0 is suppressed
    set_op1(OP_ALU, 6'd0, 4'd3, 32'd0, 32'h9);
    cyc(); idle();
    check("r0_ret", 32'(retire_en), 32'd1);
    check("r0_rf_en", 32'(phy_rf_wr_en), 32'd0);

    // reset mid-operation discards queued work
    rob_incr_tail_ptr = 1;
    for (int i = 0; i < 3; i++) begin
      set_op1(OP_ALU, 6'd20, 4'(i), 32'd0, 32'd1);
      set_op2(OP_STORE, 6'd0, 4'(4 + i), 32'd0, 32'd0);
      cyc();
    end
    idle(); rob_incr_tail_ptr = 0; rst = 0;
    cyc();
    check("mrst_ret", 32'(retire_en), 32'd0);
    check("mrst_tail", 32'(rob_tail_ptr), 32'd0);
    rst = 1;
    cyc();
    check("post_rst_ret", 32'(retire_en), 32'd0);
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
